// File: rtl/dz_digit_scan.sv
// Row-scan driver for the red/green LED dot matrix: a 4-bit digit is shown as an 8x8 glyph.
// Optional blink support is compiled in with `define DZ_BLINK_EN.
module dz_digit_scan #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      num,
    input  logic [1:0]      color,
    input  logic            num_vld,
    input  logic            blank,
    input  logic            blink,
    output logic [ROWS-1:0] row,
    output logic [COLS-1:0] colr,
    output logic [COLS-1:0] colg,
    output logic            frame_done
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);

    // Each glyph is packed row 0 in the top byte down to row 7 in the bottom byte.
    function automatic logic [7:0] glyph(input logic [3:0] n, input logic [2:0] r);
        logic [63:0] w;
        unique case (n)
            4'd0:    w = 64'h003C66666666663C;
            4'd1:    w = 64'h001838181818183C;
            4'd2:    w = 64'h003C66060C30663C;
            4'd3:    w = 64'h003C66061C06663C;
            4'd4:    w = 64'h000C1C2C4C7E0C0C;
            4'd5:    w = 64'h007E607C0606663C;
            4'd6:    w = 64'h003C607C6666663C;
            4'd7:    w = 64'h007E060C18181818;
            4'd8:    w = 64'h003C66663C66663C;
            4'd9:    w = 64'h003C66663E06063C;
            default: w = 64'h0;
        endcase
        return w[8 * (7 - int'(r)) +: 8];
    endfunction

    logic [DW-1:0]   div_q, div_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [3:0]      pend_num_q, pend_num_d, shw_num_q, shw_num_d;
    logic [1:0]      pend_col_q, pend_col_d, shw_col_q, shw_col_d;
    logic [ROWS-1:0] row_d;
    logic [COLS-1:0] colr_d, colg_d, gl;
    logic            fd_d, wrap, frame_wrap, dark;

`ifdef DZ_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
`else
    logic unused_blink;
    assign unused_blink = blink | (BLINK_FRAMES == 0);
`endif

    always_comb begin
        wrap       = (div_q == DIV_MAX);
        frame_wrap = wrap && (row_idx_q == LAST_ROW);
        div_d      = wrap ? '0 : div_q + 1'b1;
        row_idx_d  = row_idx_q;
        if (wrap) begin
            row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + 1'b1;
        end

        // The shown copy takes the pre-edge pending value, so a strobe on the wrap edge waits a frame.
        shw_num_d = frame_wrap ? pend_num_q : shw_num_q;
        shw_col_d = frame_wrap ? pend_col_q : shw_col_q;
        pend_num_d = num_vld ? num : pend_num_q;
        pend_col_d = num_vld ? color : pend_col_q;

        row_d = row;
        if (wrap) begin
            row_d = ~(ROWS'(1) << row_idx_d);
        end

        dark = blank;
`ifdef DZ_BLINK_EN
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            if (fcnt_q == FRAME_MAX) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        dark = dark | (blink & phase_d);
`endif

        gl = '0;
        if (int'(row_idx_d) < 8 && shw_num_d < 4'd10) begin
            gl[7:0] = glyph(shw_num_d, row_idx_d[2:0]);
        end
        colr_d = (shw_col_d[0] && !dark) ? gl : '0;
        colg_d = (shw_col_d[1] && !dark) ? gl : '0;
        fd_d   = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            row_idx_q  <= LAST_ROW;
            pend_num_q <= '0;
            pend_col_q <= '0;
            shw_num_q  <= '0;
            shw_col_q  <= '0;
            row        <= '1;
            colr       <= '0;
            colg       <= '0;
            frame_done <= 1'b0;
        end else begin
            div_q      <= div_d;
            row_idx_q  <= row_idx_d;
            pend_num_q <= pend_num_d;
            pend_col_q <= pend_col_d;
            shw_num_q  <= shw_num_d;
            shw_col_q  <= shw_col_d;
            row        <= row_d;
            colr       <= colr_d;
            colg       <= colg_d;
            frame_done <= fd_d;
        end
    end

`ifdef DZ_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_dz_digit_scan.sv
// Self-checking bench for dz_digit_scan: a cycle model pushes expected outputs at each
// rising edge, and a monitor pops and compares them on the falling edge.
module tb_dz_digit_scan;

    localparam int ROWS = 8, COLS = 8, SCAN_DIV = 4, BLINK_FRAMES = 2;

    logic            clk = 1'b0, rst = 1'b1;
    logic [3:0]      num = '0;
    logic [1:0]      color = '0;
    logic            num_vld = 1'b0, blank = 1'b0, blink = 1'b0;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] colr, colg;
    logic            frame_done;

    dz_digit_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .color(color), .num_vld(num_vld), .blank(blank),
        .blink(blink), .row(row), .colr(colr), .colg(colg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] row;
        logic [7:0] cr;
        logic [7:0] cg;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    logic [63:0] rom [10] = '{
        64'h003C66666666663C, 64'h001838181818183C, 64'h003C66060C30663C,
        64'h003C66061C06663C, 64'h000C1C2C4C7E0C0C, 64'h007E607C0606663C,
        64'h003C607C6666663C, 64'h007E060C18181818, 64'h003C66663C66663C,
        64'h003C66663E06063C};

    int         mdiv, mrow, mpn, mpc, msn, msc, mfc, mph;
    logic [7:0] erow;

    task automatic model_step();
        exp_t       e;
        logic [7:0] g;
        logic       wrap, fw, dark;
        if (rst) begin
            mdiv = 0; mrow = ROWS - 1; mpn = 0; mpc = 0; msn = 0; msc = 0; mfc = 0; mph = 0;
            erow = 8'hFF;
            e = '{8'hFF, 8'h00, 8'h00, 1'b0};
        end else begin
            wrap = (mdiv == SCAN_DIV - 1);
            fw   = wrap && (mrow == ROWS - 1);
            if (fw) begin
                msn = mpn; msc = mpc;
            end
            if (num_vld) begin
                mpn = int'(num); mpc = int'(color);
            end
            if (wrap) begin
                mrow = fw ? 0 : mrow + 1;
                erow = ~(8'd1 << mrow);
            end
            mdiv = wrap ? 0 : mdiv + 1;
            dark = blank;
`ifdef DZ_BLINK_EN
            if (fw) begin
                mfc = mfc + 1;
                if (mfc == BLINK_FRAMES) begin
                    mfc = 0; mph = 1 - mph;
                end
            end
            dark = dark | (blink && mph == 1);
`endif
            g = (msn < 10 && mrow < 8) ? rom[msn][8 * (7 - mrow) +: 8] : 8'h00;
            e.row = erow;
            e.cr  = (msc[0] && !dark) ? g : 8'h00;
            e.cg  = (msc[1] && !dark) ? g : 8'h00;
            e.fd  = fw;
        end
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    exp_t got;
    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("row", row, got.row);
            check("colr", colr, got.cr);
            check("colg", colg, got.cg);
            check("frame_done", frame_done, got.fd);
        end
    end

    task automatic strobe(input logic [3:0] n, input logic [1:0] c);
        @(negedge clk);
        num = n; color = c; num_vld = 1'b1;
        @(negedge clk);
        num_vld = 1'b0;
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) check("fd_timeout", frame_done, 1);
    endtask

    task automatic wait_row(input logic [7:0] target);
        int n = 0;
        while (row !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (row !== target) check("row_timeout", row, target);
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_first_row", row, 8'hFF);
        @(negedge clk);
        check("first_row0", row, 8'hFE);
        check("first_fd", frame_done, 1);
        wait_fd(n);
        check("fd_period", n, 32);
        repeat (10) @(negedge clk);

        // Mid-frame load of 4 red: shown from the next frame.
        strobe(4'd4, 2'b01);
        wait_fd(n);
        wait_row(8'hDF);
        check("d4_row5_colr", colr, 8'h7E);
        check("d4_row5_colg", colg, 8'h00);

        strobe(4'd3, 2'b11);
        wait_fd(n);
        check("d3_row0_colr", colr, 8'h00);
        check("d3_row0_colg", colg, 8'h00);
        repeat (4) @(negedge clk);
        check("d3_row1_sel", row, 8'hFD);
        check("d3_row1_colr", colr, 8'h3C);
        check("d3_row1_colg", colg, 8'h3C);

        // Two strobes in one frame, then a third landing exactly on the wrap edge.
        wait_fd(n);
        strobe(4'd5, 2'b10);
        num = 4'd2; color = 2'b10; num_vld = 1'b1;
        @(negedge clk);
        num_vld = 1'b0;
        repeat (28) @(negedge clk);
        num = 4'd9; color = 2'b10; num_vld = 1'b1;
        @(negedge clk);
        num_vld = 1'b0;
        check("wrap_edge_fd", frame_done, 1);
        wait_row(8'hDF);
        check("d2_row5_colg", colg, 8'h30);
        wait_fd(n);
        wait_row(8'hDF);
        check("d9_row5_colg", colg, 8'h06);

        strobe(4'd8, 2'b01);
        wait_fd(n);
        repeat (5) @(negedge clk);
        blank = 1'b1;
        repeat (6) @(negedge clk);
        blank = 1'b0;
        wait_fd(n);

        strobe(4'd0, 2'b01);
        blink = 1'b1;
        repeat (5) wait_fd(n);
        strobe(4'd7, 2'b01);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_row", row, 8'hFF);
        check("async_rst_colr", colr, 8'h00);
        check("async_rst_colg", colg, 8'h00);
        check("async_rst_fd", frame_done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        blink = 1'b0;
        repeat (70) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
